// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Stall / flush / halt sequencing for a 5-stage pipeline.
//            Define PIPE_PERF_EN to add the stall_cnt / flush_cnt counters.
// Revision : 1.0
// ============================================================================
module pipeline_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       idex_dMemREN,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  input  logic       exmem_dmem_req,
  input  logic       exmem_redirect,
  input  logic       exmem_halt,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       memwb_flush,
  output logic       halt_out,
  output logic [2:0] state_out
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    LUSTALL = 3'd1,
    DRAIN   = 3'd2,
    HALTED  = 3'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic       dwait;
  logic       lu_haz;

  assign dwait  = exmem_dmem_req & ~dhit;
  assign lu_haz = idex_dMemREN & (idex_rt != 5'd0) &
                  ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;

    if (RST || state_q == HALTED) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (dwait) begin
      // Freeze everything upstream; MEM/WB takes a bubble so WB never repeats.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (state_q == DRAIN) begin
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      drain_cnt_d = drain_cnt_q - 2'd1;
      if (drain_cnt_d == 2'd0) begin
        state_d = HALTED;
      end
    end else if (exmem_halt) begin
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      drain_cnt_d = 2'd2;
      state_d     = DRAIN;
    end else if (exmem_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = RUN;
    end else if (lu_haz && state_q == RUN) begin
      // LUSTALL skips this test, so one load inserts at most one bubble.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      state_d    = LUSTALL;
    end else begin
      if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
      state_d = RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      drain_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign state_out = state_q;
  assign halt_out  = ~RST & (state_q == HALTED);

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        redirect_fire;
  logic        stall_evt;

  assign redirect_fire = (state_q != HALTED) & (state_q != DRAIN) & ~dwait &
                         ~exmem_halt & exmem_redirect;
  assign stall_evt     = ~pc_en & (state_q != HALTED);

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_evt};
    flush_cnt_d = flush_cnt_q + {31'd0, redirect_fire};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state updates on the rising edge.
REQ-002 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port ihit, input, 1, instruction fetch completes this cycle.
REQ-004 SHALL have port dhit, input, 1, data access completes this cycle.
REQ-005 SHALL have port idex_dMemREN, input, 1, the instruction in EX is a load.
REQ-006 SHALL have port idex_rt, input, 5, destination register of the EX-stage load.
REQ-007 SHALL have ports ifid_rs and ifid_rt, input, 5 each, source registers of the ID-stage instruction.
REQ-008 SHALL have port ifid_uses_rt, input, 1, the ID-stage instruction reads rt.
REQ-009 SHALL have port exmem_dmem_req, input, 1, the MEM-stage instruction issues a data read or write.
REQ-010 SHALL have port exmem_redirect, input, 1, a taken branch or jump is resolved in MEM.
REQ-011 SHALL have port exmem_halt, input, 1, a halt instruction is in MEM.
REQ-012 SHALL have ports pc_en, ifid_en, idex_en, exmem_en and memwb_en, output, 1 each, latch or PC load enables.
REQ-013 SHALL have ports ifid_flush, idex_flush, exmem_flush and memwb_flush, output, 1 each; each loads a bubble into its latch.
REQ-014 SHALL have port halt_out, output, 1, processor halted (sticky).
REQ-015 SHALL have port state_out, output, 3, current FSM state (RUN=0, LUSTALL=1, DRAIN=2, HALTED=3).

Function
REQ-016 SHALL implement states RUN, LUSTALL, DRAIN and HALTED; all enable and flush outputs SHALL be combinational from the current state and the inputs.
REQ-017 SHALL compute dwait = exmem_dmem_req & ~dhit.
REQ-018 SHALL compute lu_haz = idex_dMemREN & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & idex_rt == ifid_rt)).
REQ-019 SHALL, in RUN, resolve conditions in priority order dwait > exmem_halt > exmem_redirect > lu_haz > ~ihit.
REQ-020 SHALL, on dwait in any non-HALTED state, drive all enables 0 except memwb_en=1 with memwb_flush=1; the state is held.
REQ-021 SHALL, on exmem_halt in RUN without dwait, drive pc_en=0, flush ifid/idex/exmem, memwb_en=1, load drain counter with 2 and enter DRAIN.
REQ-022 SHALL, on exmem_redirect in RUN, drive pc_en=1 and flush ifid, idex and exmem, with all other enables 1.
REQ-023 SHALL, on lu_haz in RUN, drive pc_en=0, ifid_en=0, idex_flush=1 and exmem/memwb enabled, then enter LUSTALL.
REQ-024 SHALL, in LUSTALL, skip lu_haz evaluation and apply the RUN rules otherwise, then return to RUN after exactly one cycle so that at most one bubble is inserted per load.
REQ-025 SHALL, on ~ihit alone in RUN, drive pc_en=0 and ifid_flush=1 while downstream stages advance.
REQ-026 SHALL, in DRAIN, keep pc_en=0 and the ifid/idex/exmem flushes, keep memwb_en=1, and decrement the 2-bit counter; at 0 it enters HALTED.
REQ-027 SHALL, in HALTED, drive all enables 0, all flushes 1 and halt_out=1 until RST; all inputs are ignored.
REQ-028 SHALL, when no condition applies, drive all enables 1 and all flushes 0.

Reset
REQ-029 SHALL, while RST=1, force state RUN, drain counter 0 and halt_out 0; during RST, pc_en=0, all latch enables 0, all flushes 1.
REQ-030 SHALL abort DRAIN or HALTED immediately on RST; the first cycle after RST deasserts is RUN.

Configuration
REQ-031 SHALL, with PIPE_PERF_EN defined, add output stall_cnt (32 bits) and output flush_cnt (32 bits), cleared by RST and wrapping at 2^32; stall_cnt counts cycles with pc_en=0 outside HALTED, and flush_cnt counts redirect cycles.
REQ-032 SHALL, without PIPE_PERF_EN, omit both counters and their ports entirely, with no other behaviour change.

Verification
REQ-033 SHALL cover the load-use case: a load with idex_rt=5, ifid_rs=5, ihit=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, then state LUSTALL for 1 cycle, then RUN.
REQ-034 SHALL cover the register-0 case: idex_rt=0 matching ifid_rs=0 -> no stall, all enables 1.
REQ-035 SHALL cover a data wait: exmem_dmem_req=1 with dhit=0 for 3 cycles, concurrent with exmem_redirect=1 -> 3 freeze cycles with memwb_flush=1, then one redirect cycle flushing ifid/idex/exmem.
REQ-036 SHALL cover halt: exmem_halt=1 in RUN -> DRAIN for 2 cycles, then HALTED with halt_out=1 held for 10+ cycles despite toggling inputs; RST then returns to RUN with halt_out=0.
REQ-037 SHALL cover the counters (PIPE_PERF_EN): 4 ihit=0 cycles plus 1 redirect -> stall_cnt=4 and flush_cnt=1; a preset of 0xFFFFFFFF followed by 1 stall -> stall_cnt=0.
